// File: rtl/vTPU_pkg.sv
// vTPU_pkg: shared array geometry and types for the vTPU datapath.
package vTPU_pkg;
    localparam int X = 3;
    localparam int BITWIDTH = 8;
    localparam int NUM_REG_COLUMNS = 64;
    typedef logic [BITWIDTH-1:0] act_t;
    typedef enum logic [1:0] {SKW_IDLE, SKW_STREAM, SKW_DRAIN} skew_state_t;
endpackage

// File: rtl/sa_act_skew_feeder_if.sv
// sa_act_skew_feeder_if: valid/ready beat stream (valid, ready, data lanes, last) into the skew feeder.
interface sa_act_skew_feeder_if #(
    parameter int X = vTPU_pkg::X,
    parameter int BITWIDTH = vTPU_pkg::BITWIDTH
);
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [X*BITWIDTH-1:0] data;
    modport master (output valid, data, last, input ready);
    modport slave (input valid, data, last, output ready);
endinterface

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift chain of W bits; shifts when en, sync clear on rst; q is the last stage.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] sr [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
        end else if (en) begin
            sr[0] <= d;
            for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
        end
    end
    assign q = sr[DEPTH-1];
endmodule

// File: rtl/sa_act_skew_feeder.sv
// sa_act_skew_feeder: skews activation beats into a diagonal wavefront (row i delayed i extra cycles), drains and pulses done.
// Ports: clk/rst; in_if (slave beat stream); sa_stall freezes everything; out_data/out_valid/out_last per row;
// done on final emission of row X-1; beat_cnt beats in tile; overflow sticky beyond K_MAX.
module sa_act_skew_feeder #(
    parameter int X = vTPU_pkg::X,
    parameter int BITWIDTH = vTPU_pkg::BITWIDTH,
    parameter int K_MAX = vTPU_pkg::NUM_REG_COLUMNS
) (
    input  logic                       clk,
    input  logic                       rst,
    sa_act_skew_feeder_if.slave        in_if,
    input  logic                       sa_stall,
    output logic [X*BITWIDTH-1:0]      out_data,
    output logic [X-1:0]               out_valid,
    output logic [X-1:0]               out_last,
    output logic                       done,
    output logic [$clog2(K_MAX+1)-1:0] beat_cnt,
    output logic                       overflow
);
    import vTPU_pkg::*;
    localparam int CW = $clog2(K_MAX+1);
    skew_state_t state, state_nx;
    logic advance, accept;
    assign advance = !sa_stall;
    assign in_if.ready = !sa_stall && state != SKW_DRAIN && !rst;
    assign accept = in_if.valid && in_if.ready;
    assign done = !rst && advance && state == SKW_DRAIN && out_last[X-1];
    for (genvar g = 0; g < X; g++) begin : g_row
        logic [BITWIDTH+1:0] q;
        skew_delay_line #(.DEPTH(g+1), .W(BITWIDTH+2)) u_line (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .d   (accept ? {in_if.data[g*BITWIDTH +: BITWIDTH], 1'b1, in_if.last} : '0),
            .q   (q)
        );
        assign out_data[g*BITWIDTH +: BITWIDTH] = q[BITWIDTH+1:2];
        assign out_valid[g] = q[1];
        assign out_last[g] = q[0];
    end
    always_comb begin
        state_nx = state;
        case (state)
            SKW_IDLE, SKW_STREAM: state_nx = accept ? (in_if.last ? SKW_DRAIN : SKW_STREAM) : state;
            SKW_DRAIN: state_nx = done ? SKW_IDLE : SKW_DRAIN;
            default: state_nx = SKW_IDLE;
        endcase
    end
    // beat_cnt is 0 in IDLE, so the first accept loads 1; it saturates at K_MAX once overflow is flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SKW_IDLE;
            beat_cnt <= '0;
            overflow <= 1'b0;
        end else if (advance) begin
            state <= state_nx;
            beat_cnt <= done ? '0 : accept ? beat_cnt + CW'(beat_cnt != CW'(K_MAX)) : beat_cnt;
            overflow <= overflow | (accept && beat_cnt == CW'(K_MAX));
        end
    end
endmodule
